// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// traffic_pkg : shared command codes, FSM states and time width
// Rev 1.0
// ============================================================================
package traffic_pkg;

    localparam int TIME_W = 16;

    typedef enum logic [2:0] {
        CMD_ON          = 3'd0,
        CMD_OFF         = 3'd1,
        CMD_UNC         = 3'd2,
        CMD_SET_GREEN   = 3'd3,
        CMD_SET_YELLOW  = 3'd4,
        CMD_SET_ALL_RED = 3'd5
    } cmd_e;

    typedef enum logic [3:0] {
        ST_OFF        = 4'd0,
        ST_UNC_ON     = 4'd1,
        ST_UNC_OFF    = 4'd2,
        ST_ALL_RED    = 4'd3,
        ST_RED_YELLOW = 4'd4,
        ST_GREEN      = 4'd5,
        ST_BLINK_OFF  = 4'd6,
        ST_BLINK_ON   = 4'd7,
        ST_YELLOW     = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/traffic_tick_gen.sv
`default_nettype none
// ============================================================================
// traffic_tick_gen : free-running one-cycle tick every TICK_DIV clocks
// Rev 1.0
// ============================================================================
module traffic_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk_i,
    input  logic srst_i,
    output logic tick_o
);

    localparam int                 c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tick;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
            r_tick <= (r_cnt == c_LAST);
        end
    end

    assign tick_o = r_tick;

endmodule
`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// traffic_intersection_ctrl : round-robin signal-group controller with
// flashing and off modes, runtime-programmable green/yellow/all-red times
// Rev 1.0
// ============================================================================
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int                PHASES_NUM           = 4,
    parameter int                TICK_DIV             = 100000,
    parameter logic [TIME_W-1:0] BLINK_HALF_PERIOD    = 16'd500,
    parameter logic [TIME_W-1:0] GREEN_BLINKS_NUM     = 16'd4,
    parameter logic [TIME_W-1:0] RED_YELLOW_TIME      = 16'd2000,
    parameter logic [TIME_W-1:0] ALL_RED_TIME_DEFAULT = 16'd1000,
    parameter logic [TIME_W-1:0] GREEN_TIME_DEFAULT   = 16'd8000,
    parameter logic [TIME_W-1:0] YELLOW_TIME_DEFAULT  = 16'd3000
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2:0]            cmd_type_i,
    input  logic [2:0]            cmd_phase_i,
    input  logic [TIME_W-1:0]     cmd_data_i,
    output logic [PHASES_NUM-1:0] red_o,
    output logic [PHASES_NUM-1:0] yellow_o,
    output logic [PHASES_NUM-1:0] green_o
);

    localparam int                    c_PH_W   = $clog2(PHASES_NUM);
    localparam logic [c_PH_W-1:0]     c_LAST_PH = c_PH_W'(PHASES_NUM - 1);
    localparam logic [3:0]            c_PHASES = 4'(PHASES_NUM);
    localparam logic [PHASES_NUM-1:0] c_ONE    = {{(PHASES_NUM-1){1'b0}}, 1'b1};

    state_e              r_state;
    logic [c_PH_W-1:0]   r_cur_phase;
    logic [TIME_W-1:0]   r_cnt;
    logic [TIME_W-1:0]   r_dur;
    logic [TIME_W-1:0]   r_blink_cnt;
    logic [TIME_W-1:0]   r_all_red_time;
    logic [TIME_W-1:0]   r_green_time  [PHASES_NUM];
    logic [TIME_W-1:0]   r_yellow_time [PHASES_NUM];

    logic                w_tick;
    logic                w_fire;
    logic                w_last;
    logic                w_phase_ok;
    logic                w_in_normal;
    logic [c_PH_W-1:0]   w_cmd_idx;
    logic [TIME_W-1:0]   w_data;
    logic [PHASES_NUM-1:0] w_sel;

    traffic_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .tick_o (w_tick)
    );

    assign cmd_ready_o = ~srst_i;
    assign w_fire      = cmd_valid_i & cmd_ready_o;
    assign w_last      = (r_cnt + 16'd1) >= r_dur;
    assign w_phase_ok  = {1'b0, cmd_phase_i} < c_PHASES;
    assign w_cmd_idx   = cmd_phase_i[c_PH_W-1:0];
    assign w_data      = (cmd_data_i == '0) ? 16'd1 : cmd_data_i;
    assign w_in_normal = !(r_state inside {ST_OFF, ST_UNC_ON, ST_UNC_OFF});

    // Mode-changing commands pre-empt tick transitions; SET commands only
    // rewrite stored times, so the tick still advances the state that cycle
    // and a duration latched on that same entry uses the previous value.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state        <= ST_ALL_RED;
            r_cur_phase    <= '0;
            r_cnt          <= '0;
            r_dur          <= ALL_RED_TIME_DEFAULT;
            r_blink_cnt    <= '0;
            r_all_red_time <= ALL_RED_TIME_DEFAULT;
            for (int i = 0; i < PHASES_NUM; i++) begin
                r_green_time[i]  <= GREEN_TIME_DEFAULT;
                r_yellow_time[i] <= YELLOW_TIME_DEFAULT;
            end
        end else begin
            if (w_fire && cmd_type_i == CMD_OFF) begin
                r_state <= ST_OFF;
                r_cnt   <= '0;
            end else if (w_fire && cmd_type_i == CMD_UNC) begin
                r_state <= ST_UNC_ON;
                r_cnt   <= '0;
                r_dur   <= BLINK_HALF_PERIOD;
            end else if (w_fire && cmd_type_i == CMD_ON && !w_in_normal) begin
                r_state     <= ST_ALL_RED;
                r_cur_phase <= '0;
                r_cnt       <= '0;
                r_blink_cnt <= '0;
                r_dur       <= r_all_red_time;
            end else if (w_tick && r_state != ST_OFF) begin
                if (!w_last) begin
                    r_cnt <= r_cnt + 16'd1;
                end else begin
                    r_cnt <= '0;
                    case (r_state)
                        ST_UNC_ON: begin
                            r_state <= ST_UNC_OFF;
                            r_dur   <= BLINK_HALF_PERIOD;
                        end
                        ST_UNC_OFF: begin
                            r_state <= ST_UNC_ON;
                            r_dur   <= BLINK_HALF_PERIOD;
                        end
                        ST_ALL_RED: begin
                            r_state <= ST_RED_YELLOW;
                            r_dur   <= RED_YELLOW_TIME;
                        end
                        ST_RED_YELLOW: begin
                            r_state <= ST_GREEN;
                            r_dur   <= r_green_time[r_cur_phase];
                        end
                        ST_GREEN: begin
                            if (GREEN_BLINKS_NUM == '0) begin
                                r_state <= ST_YELLOW;
                                r_dur   <= r_yellow_time[r_cur_phase];
                            end else begin
                                r_state     <= ST_BLINK_OFF;
                                r_dur       <= BLINK_HALF_PERIOD;
                                r_blink_cnt <= '0;
                            end
                        end
                        ST_BLINK_OFF: begin
                            r_state <= ST_BLINK_ON;
                            r_dur   <= BLINK_HALF_PERIOD;
                        end
                        ST_BLINK_ON: begin
                            if (r_blink_cnt + 16'd1 >= GREEN_BLINKS_NUM) begin
                                r_state <= ST_YELLOW;
                                r_dur   <= r_yellow_time[r_cur_phase];
                            end else begin
                                r_state     <= ST_BLINK_OFF;
                                r_dur       <= BLINK_HALF_PERIOD;
                                r_blink_cnt <= r_blink_cnt + 16'd1;
                            end
                        end
                        ST_YELLOW: begin
                            r_state     <= ST_ALL_RED;
                            r_dur       <= r_all_red_time;
                            r_cur_phase <= (r_cur_phase == c_LAST_PH) ? '0
                                           : r_cur_phase + c_PH_W'(1);
                        end
                        default: ;
                    endcase
                end
            end

            if (w_fire) begin
                if (cmd_type_i == CMD_SET_GREEN && w_phase_ok)
                    r_green_time[w_cmd_idx] <= w_data;
                if (cmd_type_i == CMD_SET_YELLOW && w_phase_ok)
                    r_yellow_time[w_cmd_idx] <= w_data;
                if (cmd_type_i == CMD_SET_ALL_RED)
                    r_all_red_time <= w_data;
            end
        end
    end

    assign w_sel = c_ONE << r_cur_phase;

    always_comb begin
        red_o    = '0;
        yellow_o = '0;
        green_o  = '0;
        case (r_state)
            ST_OFF, ST_UNC_OFF: ;
            ST_UNC_ON:     yellow_o = '1;
            ST_ALL_RED:    red_o    = '1;
            ST_RED_YELLOW: begin
                red_o    = '1;
                yellow_o = w_sel;
            end
            ST_GREEN, ST_BLINK_ON: begin
                red_o   = ~w_sel;
                green_o = w_sel;
            end
            ST_BLINK_OFF:  red_o = ~w_sel;
            ST_YELLOW: begin
                red_o    = ~w_sel;
                yellow_o = w_sel;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// tb_traffic_intersection_ctrl : randomized scoreboard bench against a
// segment-schedule reference model
// Rev 1.0
// ============================================================================
module tb_traffic_intersection_ctrl;

    localparam int P   = 3;
    localparam int TD  = 2;
    localparam int BHP = 2;
    localparam int NB  = 2;
    localparam int RYT = 2;
    localparam int AR  = 1;
    localparam int GR  = 3;
    localparam int YL  = 2;
    localparam int LAST_STEP = 2 * NB + 3;

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_type = '0;
    logic [2:0]   cmd_phase = '0;
    logic [15:0]  cmd_data = '0;
    logic [P-1:0] red, yellow, green;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .PHASES_NUM           (P),
        .TICK_DIV             (TD),
        .BLINK_HALF_PERIOD    (16'(BHP)),
        .GREEN_BLINKS_NUM     (16'(NB)),
        .RED_YELLOW_TIME      (16'(RYT)),
        .ALL_RED_TIME_DEFAULT (16'(AR)),
        .GREEN_TIME_DEFAULT   (16'(GR)),
        .YELLOW_TIME_DEFAULT  (16'(YL))
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_type_i  (cmd_type),
        .cmd_phase_i (cmd_phase),
        .cmd_data_i  (cmd_data),
        .red_o       (red),
        .yellow_o    (yellow),
        .green_o     (green)
    );

    typedef struct packed {
        logic [P-1:0] r;
        logic [P-1:0] y;
        logic [P-1:0] g;
    } lamps_t;

    lamps_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     live     = 1'b0;

    // Reference model: mode 0=off, 1=flashing, 2=normal; in normal mode the
    // phase is walked as a list of timed segments (step 0..LAST_STEP).
    int m_mode, m_step, m_phase, m_cnt, m_len, m_cyc, m_all_red;
    bit m_unc_on, m_tick;
    int m_green[P];
    int m_yellow[P];

    function automatic int seg_len(int k, int ph);
        if (k == 0)              return m_all_red;
        else if (k == 1)         return RYT;
        else if (k == 2)         return m_green[ph];
        else if (k == LAST_STEP) return m_yellow[ph];
        else                     return BHP;
    endfunction

    function automatic lamps_t model_lamps();
        lamps_t e;
        e = '0;
        if (m_mode == 1 && m_unc_on) begin
            e.y = '1;
        end else if (m_mode == 2) begin
            for (int i = 0; i < P; i++) begin
                if (i != m_phase) e.r[i] = 1'b1;
                else if (m_step == 0) e.r[i] = 1'b1;
                else if (m_step == 1) begin e.r[i] = 1'b1; e.y[i] = 1'b1; end
                else if (m_step == 2) e.g[i] = 1'b1;
                else if (m_step == LAST_STEP) e.y[i] = 1'b1;
                else if ((m_step - 3) % 2 == 1) e.g[i] = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            live = 1'b1;
            m_mode = 2; m_step = 0; m_phase = 0; m_cnt = 0; m_cyc = 0;
            m_all_red = AR; m_len = AR; m_unc_on = 1'b0;
            for (int i = 0; i < P; i++) begin
                m_green[i] = GR;
                m_yellow[i] = YL;
            end
        end else if (live) begin
            m_tick = (m_cyc > 0) && (m_cyc % TD == 0);
            m_cyc++;
            if (cmd_valid && cmd_type == 3'd1) begin
                m_mode = 0;
            end else if (cmd_valid && cmd_type == 3'd2) begin
                m_mode = 1; m_unc_on = 1'b1; m_cnt = 0; m_len = BHP;
            end else if (cmd_valid && cmd_type == 3'd0 && m_mode != 2) begin
                m_mode = 2; m_step = 0; m_phase = 0; m_cnt = 0; m_len = m_all_red;
            end else if (m_tick && m_mode != 0) begin
                m_cnt++;
                if (m_cnt >= m_len) begin
                    m_cnt = 0;
                    if (m_mode == 1) begin
                        m_unc_on = !m_unc_on;
                        m_len = BHP;
                    end else begin
                        m_step++;
                        if (m_step > LAST_STEP) begin
                            m_step = 0;
                            m_phase = (m_phase + 1) % P;
                        end
                        m_len = seg_len(m_step, m_phase);
                    end
                end
            end
            if (cmd_valid) begin
                if (cmd_type == 3'd3 && cmd_phase < P)
                    m_green[cmd_phase] = (cmd_data == 0) ? 1 : int'(cmd_data);
                if (cmd_type == 3'd4 && cmd_phase < P)
                    m_yellow[cmd_phase] = (cmd_data == 0) ? 1 : int'(cmd_data);
                if (cmd_type == 3'd5)
                    m_all_red = (cmd_data == 0) ? 1 : int'(cmd_data);
            end
        end
        if (live) exp_q.push_back(model_lamps());
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    endtask

    always @(negedge clk) begin
        lamps_t e;
        if (live) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty at %0t: actual=empty required=entry", $time);
            end else begin
                e = exp_q.pop_front();
                chk("red_o",    32'(red),    32'(e.r));
                chk("yellow_o", 32'(yellow), 32'(e.y));
                chk("green_o",  32'(green),  32'(e.g));
            end
            chk("cmd_ready_o", 32'(cmd_ready), 32'(!srst));
        end
    end

    function automatic bit cond(input int which);
        case (which)
            0: return green[1];
            1: return (yellow == 3'b100) && (red == 3'b011);
            2: return (red == 3'b111) && (yellow == '0) && (green == '0);
            3: return green != '0;
            4: return (red != 3'b111) && (red != '0) && (yellow == '0) && (green == '0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int which, input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cond(which)) return;
        end
        n_checks++;
        $display("FAIL wait_%s: actual=timeout required=condition within 400 cycles", name);
    endtask

    task automatic issue(input logic [2:0] t, input logic [2:0] ph, input logic [15:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_type = t; cmd_phase = ph; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic reset_pulse(input logic with_cmd, input logic [2:0] t);
        @(posedge clk); #1;
        srst = 1'b1; cmd_valid = with_cmd; cmd_type = t; cmd_phase = 3'd0; cmd_data = 16'd7;
        @(posedge clk); #1;
        srst = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] t;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;

        // Free run: three phases served in order, wrap back to phase 0.
        repeat (110) @(posedge clk);

        // Reprogram phase 1 green while it is green.
        wait_cond(0, "phase1_green");
        issue(3'd3, 3'd1, 16'd5);
        repeat (120) @(posedge clk);

        // Flashing from phase-2 yellow, then back to normal.
        wait_cond(1, "phase2_yellow");
        issue(3'd2, 3'd0, 16'd0);
        repeat (20) @(posedge clk);
        issue(3'd0, 3'd0, 16'd0);
        repeat (10) @(posedge clk);

        // Zero data saturates to 1, out-of-range phase ignored, retained over OFF.
        issue(3'd1, 3'd0, 16'd0);
        issue(3'd4, 3'd0, 16'd0);
        issue(3'd3, 3'd5, 16'd9);
        issue(3'd0, 3'd0, 16'd0);
        repeat (40) @(posedge clk);

        // OFF landing on the last green tick.
        wait_cond(2, "all_red");
        wait_cond(3, "green_start");
        repeat (4) @(posedge clk);
        issue(3'd1, 3'd0, 16'd0);
        repeat (6) @(posedge clk);
        issue(3'd0, 3'd0, 16'd0);

        // Reset in BLINK_OFF with a competing command.
        wait_cond(4, "blink_off");
        reset_pulse(1'b1, 3'd2);
        repeat (80) @(posedge clk);

        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 25)) @(posedge clk);
            if ($urandom_range(0, 99) < 3) begin
                reset_pulse(1'b1, 3'($urandom_range(0, 7)));
            end else begin
                t = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) t = 3'd0;
                issue(t, 3'($urandom_range(0, 4)), 16'($urandom_range(0, 4)));
            end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
